// File: rtl/satswarm_pkg.sv
// Shared types for the satswarm host loader: literal encoding, error causes and loader FSM states.
// Default store sizes live here so the literal width follows MAX_VARS.
package satswarm_pkg;

    localparam int MAX_VARS_DEF    = 42;
    localparam int MAX_CLAUSES_DEF = 104;
    localparam int MAX_LITS_DEF    = 416;

    // Bits needed to hold a variable index in 1..max_vars.
    function automatic int calc_var_w(input int max_vars);
        return (max_vars < 2) ? 1 : $clog2(max_vars + 1);
    endfunction

    localparam int VAR_W = calc_var_w(MAX_VARS_DEF);

    typedef struct packed {
        logic             neg;
        logic [VAR_W-1:0] var_idx;
    } lit_t;

    typedef enum logic [2:0] {
        ERR_NONE        = 3'd0,
        ERR_ZERO_LIT    = 3'd1,
        ERR_VAR_RANGE   = 3'd2,
        ERR_LIT_FULL    = 3'd3,
        ERR_CLS_FULL    = 3'd4,
        ERR_OPEN_CLAUSE = 3'd5
    } err_t;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SOLVE = 2'd1,
        ERROR = 2'd2
    } loader_state_t;

endpackage

// File: rtl/host_clause_loader.sv
// Host literal-stream loader: packs DIMACS literals into the literal RAM and commits clause-table entries.
// Optional unit-clause pulse enabled by macro SATSWARM_LOADER_UNIT_EN.
module host_clause_loader
    import satswarm_pkg::*;
#(
    parameter int MAX_VARS    = MAX_VARS_DEF,
    parameter int MAX_CLAUSES = MAX_CLAUSES_DEF,
    parameter int MAX_LITS    = MAX_LITS_DEF,
    localparam int LIT_AW     = $clog2(MAX_LITS),
    localparam int LEN_W      = LIT_AW + 1,
    localparam int CLS_AW     = $clog2(MAX_CLAUSES),
    localparam int CNT_W      = CLS_AW + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                host_load_valid,
    input  logic signed [31:0]  host_load_literal,
    input  logic                host_load_clause_end,
    output logic                host_load_ready,
    input  logic                host_start,
    output logic                lit_wr_en,
    output logic [LIT_AW-1:0]   lit_wr_addr,
    output logic [VAR_W:0]      lit_wr_data,
    output logic                cls_wr_en,
    output logic [CLS_AW-1:0]   cls_wr_idx,
    output logic [LIT_AW-1:0]   cls_wr_start,
    output logic [LEN_W-1:0]    cls_wr_len,
    output logic [CNT_W-1:0]    num_clauses,
    output logic [VAR_W-1:0]    num_vars,
    output logic                load_done,
    output logic                load_err,
    output logic [2:0]          err_code,
    output logic                unit_valid,
    output logic [VAR_W:0]      unit_lit,
    output logic [1:0]          dbg_state
);

    localparam logic [31:0] MAX_VARS_U = MAX_VARS;

    // Handshake: a beat transfers on a rising clk edge where host_load_valid && host_load_ready;
    // ready is registered, only ever 1 in LOAD, and never depends on host_load_valid.

    loader_state_t     state_q, state_d;
    err_t              err_code_q, err_code_d;
    logic              ready_q, ready_d;
    logic [LIT_AW-1:0] lit_ptr_q, lit_ptr_d;
    logic [LIT_AW-1:0] clause_start_q, clause_start_d;
    logic [LEN_W-1:0]  cur_len_q, cur_len_d;
    logic [CNT_W-1:0]  num_clauses_q, num_clauses_d;
    logic [VAR_W-1:0]  num_vars_q, num_vars_d;

    logic              lit_wr_en_q, lit_wr_en_d;
    logic [LIT_AW-1:0] lit_wr_addr_q, lit_wr_addr_d;
    lit_t              lit_wr_data_q, lit_wr_data_d;
    logic              cls_wr_en_q, cls_wr_en_d;
    logic [CLS_AW-1:0] cls_wr_idx_q, cls_wr_idx_d;
    logic [LIT_AW-1:0] cls_wr_start_q, cls_wr_start_d;
    logic [LEN_W-1:0]  cls_wr_len_q, cls_wr_len_d;

    logic              beat;
    logic              lit_neg;
    logic [31:0]       lit_mag;
    err_t              beat_err;

    always_comb begin
        lit_neg = host_load_literal[31];
        // -2^31 negates to itself; as unsigned it is still far above MAX_VARS.
        lit_mag = lit_neg ? 32'(-host_load_literal) : 32'(host_load_literal);
        beat    = host_load_valid && ready_q && (state_q == LOAD);

        beat_err = ERR_NONE;
        if (host_load_literal == 32'sd0)
            beat_err = ERR_ZERO_LIT;
        else if (lit_mag > MAX_VARS_U)
            beat_err = ERR_VAR_RANGE;
        else if (lit_ptr_q == LIT_AW'(MAX_LITS))
            beat_err = ERR_LIT_FULL;
        else if (host_load_clause_end && (num_clauses_q == CNT_W'(MAX_CLAUSES)))
            beat_err = ERR_CLS_FULL;
    end

    always_comb begin
        state_d        = state_q;
        err_code_d     = err_code_q;
        lit_ptr_d      = lit_ptr_q;
        clause_start_d = clause_start_q;
        cur_len_d      = cur_len_q;
        num_clauses_d  = num_clauses_q;
        num_vars_d     = num_vars_q;
        lit_wr_en_d    = 1'b0;
        lit_wr_addr_d  = lit_wr_addr_q;
        lit_wr_data_d  = lit_wr_data_q;
        cls_wr_en_d    = 1'b0;
        cls_wr_idx_d   = cls_wr_idx_q;
        cls_wr_start_d = cls_wr_start_q;
        cls_wr_len_d   = cls_wr_len_q;

        if (beat && (beat_err != ERR_NONE)) begin
            state_d    = ERROR;
            err_code_d = beat_err;
        end else begin
            if (beat) begin
                lit_wr_en_d           = 1'b1;
                lit_wr_addr_d         = lit_ptr_q;
                lit_wr_data_d.neg     = lit_neg;
                lit_wr_data_d.var_idx = lit_mag[VAR_W-1:0];
                lit_ptr_d             = lit_ptr_q + LIT_AW'(1);
                cur_len_d             = cur_len_q + LEN_W'(1);
                if (lit_mag[VAR_W-1:0] > num_vars_q)
                    num_vars_d = lit_mag[VAR_W-1:0];
                if (host_load_clause_end) begin
                    cls_wr_en_d    = 1'b1;
                    cls_wr_idx_d   = num_clauses_q[CLS_AW-1:0];
                    cls_wr_start_d = clause_start_q;
                    cls_wr_len_d   = cur_len_q + LEN_W'(1);
                    num_clauses_d  = num_clauses_q + CNT_W'(1);
                    clause_start_d = lit_ptr_q + LIT_AW'(1);
                    cur_len_d      = '0;
                end
            end
            // Start is judged on the state after any same-cycle beat.
            if ((state_q == LOAD) && host_start) begin
                if (cur_len_d != '0) begin
                    state_d    = ERROR;
                    err_code_d = ERR_OPEN_CLAUSE;
                end else begin
                    state_d = SOLVE;
                end
            end
        end

        ready_d = (state_d == LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= LOAD;
            err_code_q     <= ERR_NONE;
            ready_q        <= 1'b0;
            lit_ptr_q      <= '0;
            clause_start_q <= '0;
            cur_len_q      <= '0;
            num_clauses_q  <= '0;
            num_vars_q     <= '0;
            lit_wr_en_q    <= 1'b0;
            lit_wr_addr_q  <= '0;
            lit_wr_data_q  <= '0;
            cls_wr_en_q    <= 1'b0;
            cls_wr_idx_q   <= '0;
            cls_wr_start_q <= '0;
            cls_wr_len_q   <= '0;
        end else begin
            state_q        <= state_d;
            err_code_q     <= err_code_d;
            ready_q        <= ready_d;
            lit_ptr_q      <= lit_ptr_d;
            clause_start_q <= clause_start_d;
            cur_len_q      <= cur_len_d;
            num_clauses_q  <= num_clauses_d;
            num_vars_q     <= num_vars_d;
            lit_wr_en_q    <= lit_wr_en_d;
            lit_wr_addr_q  <= lit_wr_addr_d;
            lit_wr_data_q  <= lit_wr_data_d;
            cls_wr_en_q    <= cls_wr_en_d;
            cls_wr_idx_q   <= cls_wr_idx_d;
            cls_wr_start_q <= cls_wr_start_d;
            cls_wr_len_q   <= cls_wr_len_d;
        end
    end

`ifdef SATSWARM_LOADER_UNIT_EN
    logic unit_valid_q, unit_valid_d;
    lit_t unit_lit_q, unit_lit_d;

    always_comb begin
        unit_valid_d = 1'b0;
        unit_lit_d   = '0;
        if (cls_wr_en_d && (cls_wr_len_d == LEN_W'(1))) begin
            unit_valid_d = 1'b1;
            unit_lit_d   = lit_wr_data_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unit_valid_q <= 1'b0;
            unit_lit_q   <= '0;
        end else begin
            unit_valid_q <= unit_valid_d;
            unit_lit_q   <= unit_lit_d;
        end
    end

    assign unit_valid = unit_valid_q;
    assign unit_lit   = unit_lit_q;
`else
    assign unit_valid = 1'b0;
    assign unit_lit   = '0;
`endif

    assign host_load_ready = ready_q;
    assign lit_wr_en       = lit_wr_en_q;
    assign lit_wr_addr     = lit_wr_addr_q;
    assign lit_wr_data     = lit_wr_data_q;
    assign cls_wr_en       = cls_wr_en_q;
    assign cls_wr_idx      = cls_wr_idx_q;
    assign cls_wr_start    = cls_wr_start_q;
    assign cls_wr_len      = cls_wr_len_q;
    assign num_clauses     = num_clauses_q;
    assign num_vars        = num_vars_q;
    assign load_done       = (state_q == SOLVE);
    assign load_err        = (state_q == ERROR);
    assign err_code        = err_code_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_host_clause_loader.sv
// Directed self-checking bench for host_clause_loader (default sizes 42 vars / 104 clauses / 416 lits).
// Honours SATSWARM_LOADER_UNIT_EN for the unit-clause expectations.
module tb_host_clause_loader;

    logic               clk;
    logic               rst_n;
    logic               host_load_valid;
    logic signed [31:0] host_load_literal;
    logic               host_load_clause_end;
    logic               host_load_ready;
    logic               host_start;
    logic               lit_wr_en;
    logic [8:0]         lit_wr_addr;
    logic [6:0]         lit_wr_data;
    logic               cls_wr_en;
    logic [6:0]         cls_wr_idx;
    logic [8:0]         cls_wr_start;
    logic [9:0]         cls_wr_len;
    logic [7:0]         num_clauses;
    logic [5:0]         num_vars;
    logic               load_done;
    logic               load_err;
    logic [2:0]         err_code;
    logic               unit_valid;
    logic [6:0]         unit_lit;
    logic [1:0]         dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    host_clause_loader dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .host_load_valid      (host_load_valid),
        .host_load_literal    (host_load_literal),
        .host_load_clause_end (host_load_clause_end),
        .host_load_ready      (host_load_ready),
        .host_start           (host_start),
        .lit_wr_en            (lit_wr_en),
        .lit_wr_addr          (lit_wr_addr),
        .lit_wr_data          (lit_wr_data),
        .cls_wr_en            (cls_wr_en),
        .cls_wr_idx           (cls_wr_idx),
        .cls_wr_start         (cls_wr_start),
        .cls_wr_len           (cls_wr_len),
        .num_clauses          (num_clauses),
        .num_vars             (num_vars),
        .load_done            (load_done),
        .load_err             (load_err),
        .err_code             (err_code),
        .unit_valid           (unit_valid),
        .unit_lit             (unit_lit),
        .dbg_state            (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: sim time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // advance one edge and settle outputs
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        host_load_valid      = 1'b0;
        host_load_literal    = '0;
        host_load_clause_end = 1'b0;
        host_start           = 1'b0;
        rst_n                = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic beat(input int lit, input logic ce);
        host_load_valid      = 1'b1;
        host_load_literal    = lit;
        host_load_clause_end = ce;
        step();
        host_load_valid      = 1'b0;
        host_load_literal    = '0;
        host_load_clause_end = 1'b0;
    endtask

    task automatic pulse_start();
        host_start = 1'b1;
        step();
        host_start = 1'b0;
    endtask

    // 416 literals, 4 per clause, magnitudes cycling 1..42, odd beats negative
    task automatic fill_all();
        for (int i = 0; i < 416; i++) begin
            int v;
            v = (i % 42) + 1;
            beat((i % 2 == 1) ? -v : v, (i % 4) == 3);
        end
    endtask

    initial begin
        // reset values while rst_n is low
        rst_n                = 1'b0;
        host_load_valid      = 1'b1;
        host_load_literal    = 32'sd5;
        host_load_clause_end = 1'b1;
        host_start           = 1'b0;
        step();
        step();
        check("rst_ready",   {63'd0, host_load_ready}, 64'd0);
        check("rst_lit_wr",  {63'd0, lit_wr_en}, 64'd0);
        check("rst_cls_wr",  {63'd0, cls_wr_en}, 64'd0);
        check("rst_ncls",    {56'd0, num_clauses}, 64'd0);
        check("rst_nvars",   {58'd0, num_vars}, 64'd0);
        check("rst_done",    {63'd0, load_done}, 64'd0);
        check("rst_err",     {63'd0, load_err}, 64'd0);
        check("rst_code",    {61'd0, err_code}, 64'd0);
        host_load_valid = 1'b0;
        rst_n = 1'b1;
        step();
        check("ready_after_rst", {63'd0, host_load_ready}, 64'd1);

        // stream {1,-2,0}{3,0}
        beat(1, 1'b0);
        check("s1_lit_en",   {63'd0, lit_wr_en}, 64'd1);
        check("s1_lit_addr", {55'd0, lit_wr_addr}, 64'd0);
        check("s1_lit_data", {57'd0, lit_wr_data}, 64'h01);
        check("s1_cls_en",   {63'd0, cls_wr_en}, 64'd0);
        beat(-2, 1'b1);
        check("s2_lit_addr", {55'd0, lit_wr_addr}, 64'd1);
        check("s2_lit_data", {57'd0, lit_wr_data}, 64'h42);
        check("s2_cls_en",   {63'd0, cls_wr_en}, 64'd1);
        check("s2_cls_idx",  {57'd0, cls_wr_idx}, 64'd0);
        check("s2_cls_start",{55'd0, cls_wr_start}, 64'd0);
        check("s2_cls_len",  {54'd0, cls_wr_len}, 64'd2);
        check("s2_unit",     {63'd0, unit_valid}, 64'd0);
        beat(3, 1'b1);
        check("s3_lit_addr", {55'd0, lit_wr_addr}, 64'd2);
        check("s3_lit_data", {57'd0, lit_wr_data}, 64'h03);
        check("s3_cls_idx",  {57'd0, cls_wr_idx}, 64'd1);
        check("s3_cls_start",{55'd0, cls_wr_start}, 64'd2);
        check("s3_cls_len",  {54'd0, cls_wr_len}, 64'd1);
`ifdef SATSWARM_LOADER_UNIT_EN
        check("s3_unit_v",   {63'd0, unit_valid}, 64'd1);
        check("s3_unit_lit", {57'd0, unit_lit}, 64'h03);
`else
        check("s3_unit_v",   {63'd0, unit_valid}, 64'd0);
        check("s3_unit_lit", {57'd0, unit_lit}, 64'h00);
`endif
        check("s_done_pre",  {63'd0, load_done}, 64'd0);
        pulse_start();
        check("s_ncls",      {56'd0, num_clauses}, 64'd2);
        check("s_nvars",     {58'd0, num_vars}, 64'd3);
        check("s_done",      {63'd0, load_done}, 64'd1);
        check("s_ready",     {63'd0, host_load_ready}, 64'd0);
        check("s_state",     {62'd0, dbg_state}, 64'd1);
        beat(7, 1'b1);
        check("solve_ignore",{63'd0, lit_wr_en}, 64'd0);
        check("solve_ncls",  {56'd0, num_clauses}, 64'd2);

        // variable out of range
        do_reset();
        beat(43, 1'b0);
        check("rng_lit_en",  {63'd0, lit_wr_en}, 64'd0);
        check("rng_err",     {63'd0, load_err}, 64'd1);
        check("rng_code",    {61'd0, err_code}, 64'd2);
        check("rng_ready",   {63'd0, host_load_ready}, 64'd0);
        beat(0, 1'b0);
        check("rng_frozen",  {61'd0, err_code}, 64'd2);

        // -2^31 and zero literal
        do_reset();
        beat(32'sh8000_0000, 1'b1);
        check("min_code",    {61'd0, err_code}, 64'd2);
        check("min_cls_en",  {63'd0, cls_wr_en}, 64'd0);
        do_reset();
        beat(0, 1'b1);
        check("zero_code",   {61'd0, err_code}, 64'd1);
        check("zero_lit_en", {63'd0, lit_wr_en}, 64'd0);

        // fill literal RAM and clause table exactly, then overflow
        do_reset();
        fill_all();
        check("full_lit_addr", {55'd0, lit_wr_addr}, 64'd415);
        check("full_lit_data", {57'd0, lit_wr_data}, 64'h66);
        check("full_cls_idx",  {57'd0, cls_wr_idx}, 64'd103);
        check("full_cls_start",{55'd0, cls_wr_start}, 64'd412);
        check("full_cls_len",  {54'd0, cls_wr_len}, 64'd4);
        check("full_ncls",     {56'd0, num_clauses}, 64'd104);
        check("full_nvars",    {58'd0, num_vars}, 64'd42);
        check("full_no_err",   {63'd0, load_err}, 64'd0);
        beat(1, 1'b1);
        check("over_code",     {61'd0, err_code}, 64'd3);
        check("over_lit_en",   {63'd0, lit_wr_en}, 64'd0);
        do_reset();
        fill_all();
        pulse_start();
        check("full_start_done", {63'd0, load_done}, 64'd1);

        // clause table full with room left in literal RAM
        do_reset();
        for (int i = 0; i < 104; i++) beat(1, 1'b1);
        check("ctab_ncls",   {56'd0, num_clauses}, 64'd104);
        check("ctab_no_err", {63'd0, load_err}, 64'd0);
        beat(2, 1'b1);
        check("ctab_code",   {61'd0, err_code}, 64'd4);

        // open clause at start
        do_reset();
        beat(5, 1'b0);
        pulse_start();
        check("open_code",   {61'd0, err_code}, 64'd5);
        check("open_err",    {63'd0, load_err}, 64'd1);
        check("open_done",   {63'd0, load_done}, 64'd0);

        // beat without clause_end in the start cycle
        do_reset();
        host_start = 1'b1;
        beat(6, 1'b0);
        host_start = 1'b0;
        check("same_open_code", {61'd0, err_code}, 64'd5);

        // beat with clause_end in the start cycle
        do_reset();
        host_start = 1'b1;
        beat(-4, 1'b1);
        host_start = 1'b0;
        check("same_done",   {63'd0, load_done}, 64'd1);
        check("same_cls_len",{54'd0, cls_wr_len}, 64'd1);
        check("same_lit",    {57'd0, lit_wr_data}, 64'h44);
`ifdef SATSWARM_LOADER_UNIT_EN
        check("same_unit_v", {63'd0, unit_valid}, 64'd1);
        check("same_unit_lit", {57'd0, unit_lit}, 64'h44);
`else
        check("same_unit_v", {63'd0, unit_valid}, 64'd0);
`endif

        // zero clauses at start
        do_reset();
        pulse_start();
        check("empty_done",  {63'd0, load_done}, 64'd1);
        check("empty_ncls",  {56'd0, num_clauses}, 64'd0);

        // reset mid-load discards progress
        do_reset();
        beat(1, 1'b1);
        beat(2, 1'b1);
        beat(3, 1'b1);
        check("mid_ncls",    {56'd0, num_clauses}, 64'd3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ncls",{56'd0, num_clauses}, 64'd0);
        step();
        check("mid_rst_wr",  {63'd0, lit_wr_en}, 64'd0);
        rst_n = 1'b1;
        step();
        beat(2, 1'b1);
        check("reload_addr", {55'd0, lit_wr_addr}, 64'd0);
        check("reload_idx",  {57'd0, cls_wr_idx}, 64'd0);
        check("reload_ncls", {56'd0, num_clauses}, 64'd1);
        check("reload_nvars",{58'd0, num_vars}, 64'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
